// File: rtl/sw_rst_debounce.sv
// Soft-reset push-button conditioner: synchroniser, confirm-counter debounce, strobes.
// Define SW_RST_HOLD_EN to build the long-press detector driving hold_p.
module sw_rst_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int HOLD_CYCLES     = 1000000,
    parameter int HOLD_W          = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_clean,
    output logic press_p,
    output logic release_p,
    output logic hold_p
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_db
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > (2 ** HOLD_W) - 1) begin : g_bad_hold
        $error("HOLD_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        REL    = 2'd0,
        CONF_P = 2'd1,
        PRS    = 2'd2,
        CONF_R = 2'd3
    } state_t;

    localparam logic IDLE = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   lvl;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
    end

    assign lvl = sync_q[SYNC_STAGES-1] ^ IDLE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            REL: begin
                if (lvl) begin
                    state_d = CONF_P;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CONF_P: begin
                if (!lvl) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRS;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRS: begin
                if (!lvl) begin
                    state_d = CONF_R;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CONF_R: begin
                if (lvl) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = REL;
                    cnt_d     = '0;
                    clean_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
                clean_d = 1'b0;
            end
        endcase
    end

    // Sync chain resets to the idle pin level so release of reset cannot look like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= {SYNC_STAGES{IDLE}};
            state_q   <= REL;
            cnt_q     <= '0;
            clean_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign sw_clean  = clean_q;
    assign press_p   = press_q;
    assign release_p = release_q;

`ifdef SW_RST_HOLD_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_q, hold_d;
    logic              held;

    assign held = (state_q == PRS) || (state_q == CONF_R);

    // Counter parks one past the threshold, so the strobe fires once per press.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_d     = 1'b0;
        if (!held) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_TOP) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
            hold_d     = (hold_cnt_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign hold_p = hold_q;
`else
    assign hold_p = 1'b0;
`endif

endmodule

// File: tb/tb_sw_rst_debounce.sv
// Randomised and directed bench for sw_rst_debounce against a run-length model.
module tb_sw_rst_debounce;

    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam int HOLD = 32;
`ifdef SW_RST_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic sw_raw;
    logic sw_clean, press_p, release_p, hold_p;

    int checks = 0;
    int errors = 0;

    // Model: raw pin delayed by the synchroniser, clean flips after DB differing samples.
    logic hist[$];
    logic m_clean, m_press, m_rel, m_hold;
    int   m_run, m_age;

    sw_rst_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (16),
        .ACTIVE_LOW     (1),
        .HOLD_CYCLES    (HOLD),
        .HOLD_W         (20)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .press_p  (press_p),
        .release_p(release_p),
        .hold_p   (hold_p)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [3:0] dut_v();
        return {sw_clean, press_p, release_p, hold_p};
    endfunction

    function automatic logic [3:0] exp_v();
        return {m_clean, m_press, m_rel, m_hold};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b1);
        m_clean = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_hold  = 1'b0;
        m_run   = 0;
        m_age   = 0;
    endtask

    task automatic cyc(input logic raw);
        logic r, lvl, was;
        sw_raw = raw;
        @(posedge clk);
        hist.push_back(raw);
        r   = hist.pop_front();
        lvl = ~r;
        was = m_clean;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_hold  = 1'b0;
        if (lvl != m_clean) begin
            m_run++;
            if (m_run == DB) begin
                m_clean = lvl;
                m_run   = 0;
                m_press = lvl;
                m_rel   = ~lvl;
            end
        end else begin
            m_run = 0;
        end
        if (was) begin
            m_age++;
            m_hold = HOLD_ON && (m_age == HOLD);
        end else begin
            m_age = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        sw_raw  = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut_v() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state obs=%b exp=0000", dut_v());
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            checks++;
            if (dut_v() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d obs=%b exp=0000", i, dut_v());
            end
        end
    endtask

    task automatic test_press();
        int  k = 0;
        bit  found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1'b0);
            k++;
            checks++;
            if (dut_v() !== exp_v()) begin
                errors++;
                $display("FAIL press_model cyc=%0d obs=%b exp=%b", i, dut_v(), exp_v());
            end
            if (sw_clean === 1'b1) found = 1;
        end
        checks++;
        if (!found || k != SYNC + DB || press_p !== 1'b1) begin
            errors++;
            $display("FAIL press_latency obs=%0d press=%b exp=%0d", k, press_p, SYNC + DB);
        end
        cyc(1'b0);
        checks++;
        if (press_p !== 1'b0 || sw_clean !== 1'b1) begin
            errors++;
            $display("FAIL press_width obs=%b%b exp=10", sw_clean, press_p);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            checks++;
            if (dut_v() !== exp_v()) begin
                errors++;
                $display("FAIL press_release cyc=%0d obs=%b exp=%b", i, dut_v(), exp_v());
            end
        end
    endtask

    task automatic test_short_press();
        int presses = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(i < 5 ? 1'b0 : 1'b1);
            if (press_p === 1'b1 || sw_clean !== 1'b0) presses++;
            checks++;
            if (dut_v() !== exp_v()) begin
                errors++;
                $display("FAIL short_model cyc=%0d obs=%b exp=%b", i, dut_v(), exp_v());
            end
        end
        checks++;
        if (presses != 0) begin
            errors++;
            $display("FAIL short_press obs=%0d exp=0", presses);
        end
    endtask

    task automatic test_bounce_release();
        int drops = 0;
        int rels = 0;
        int at = -1;
        for (int i = 0; i < 20; i++) cyc(1'b0);
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 6; i++) begin
                cyc(i < 3 ? 1'b1 : 1'b0);
                if (sw_clean !== 1'b1 || release_p !== 1'b0) drops++;
                checks++;
                if (dut_v() !== exp_v()) begin
                    errors++;
                    $display("FAIL bounce_model g=%0d obs=%b exp=%b", g, dut_v(), exp_v());
                end
            end
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL bounce_hold obs=%0d exp=0", drops);
        end
        for (int i = 1; i <= 25; i++) begin
            cyc(1'b1);
            if (release_p === 1'b1) begin
                rels++;
                at = i;
            end
            checks++;
            if (dut_v() !== exp_v()) begin
                errors++;
                $display("FAIL bounce_rel_model cyc=%0d obs=%b exp=%b", i, dut_v(), exp_v());
            end
        end
        checks++;
        if (rels != 1 || at != SYNC + DB || sw_clean !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release obs=%0d@%0d exp=1@%0d", rels, at, SYNC + DB);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        bit found = 0;
        for (int i = 0; i < 15; i++) cyc(1'b0);
        sw_raw  = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut_v() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pressed obs=%b exp=0000", dut_v());
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) cyc(1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut_v() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_conf obs=%b exp=0000", dut_v());
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1'b0);
            k++;
            if (sw_clean === 1'b1) found = 1;
        end
        checks++;
        if (!found || k != SYNC + DB) begin
            errors++;
            $display("FAIL reset_restart obs=%0d exp=%0d", k, SYNC + DB);
        end
        for (int i = 0; i < 20; i++) cyc(1'b1);
    endtask

    task automatic test_hold();
        int n = 0;
        int at = -1;
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1'b0);
            if (press_p === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL hold_press obs=0 exp=1");
        end
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b0);
            if (hold_p === 1'b1) begin
                n++;
                at = i;
            end
            checks++;
            if (dut_v() !== exp_v()) begin
                errors++;
                $display("FAIL hold_model cyc=%0d obs=%b exp=%b", i, dut_v(), exp_v());
            end
        end
        checks++;
        if (HOLD_ON ? (n != 1 || at != HOLD) : (n != 0)) begin
            errors++;
            $display("FAIL hold_pulse obs=%0d@%0d exp=%0d@%0d", n, at, HOLD_ON, HOLD);
        end
        for (int i = 0; i < 20; i++) cyc(1'b1);
    endtask

    task automatic test_random();
        int cnt = 0;
        while (cnt < 1500) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                cyc(v);
                cnt++;
                checks++;
                if (dut_v() !== exp_v() || (press_p && release_p)) begin
                    errors++;
                    $display("FAIL random cyc=%0d obs=%b exp=%b", cnt, dut_v(), exp_v());
                end
            end
        end
    endtask

    initial begin
        sw_raw  = 1'b1;
        reset_n = 1'b0;
        model_reset();
        test_reset();
        test_press();
        test_short_press();
        test_bounce_release();
        test_reset_mid();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
